// File: rtl/cnn_layer_accel_weight_sequence_ctrl.sv
// cnn_layer_accel_weight_sequence_ctrl
//
// Walks the weight sequence table for a CNN layer.
//
// A run covers num_rows row passes. Each row pass is 2*C_SEQ_LEN table reads.
// The first C_SEQ_LEN reads use sequence_selector=1 and the second C_SEQ_LEN
// reads use sequence_selector=0. gray_code counts row passes in gray order:
// 00, 01, 11, 10.
//
// Handshake: seq_vld is a plain per-cycle qualifier with no ready. When
// seq_vld=1, gray_code, sequence_selector and seq_data_addr form one table
// request in that cycle. wht_addr_vld is seq_vld delayed one cycle, so it
// lines up with the registered table output.
//
// Optional feature: defining CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN makes stall
// freeze the sequence while the FSM is in RUN. If the macro is not defined,
// stall is ignored.
//
// state_dbg exposes the FSM state: 0=IDLE, 1=RUN, 2=DRAIN.
module cnn_layer_accel_weight_sequence_ctrl #(
  parameter int C_SEQ_LEN = 5,
  parameter int C_ROW_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [C_ROW_W-1:0] num_rows,
  input  logic               stall,
  output logic [1:0]         gray_code,
  output logic               sequence_selector,
  output logic [2:0]         seq_data_addr,
  output logic               seq_vld,
  output logic               wht_addr_vld,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] ADDR_LAST = 3'(C_SEQ_LEN - 1);

  state_t             state_q, state_d;
  logic [C_ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [C_ROW_W-1:0] num_rows_q, num_rows_d;
  logic [C_ROW_W-1:0] row_inc;
  logic [2:0]         addr_q, addr_d;
  logic               sel_q, sel_d;
  logic [1:0]         gray_q, gray_d;
  logic               wvld_q;
  logic               stall_eff;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
  assign stall_eff = stall;
`else
  // The stall port stays on the module but has no effect in this build.
  assign stall_eff = stall & 1'b0;
`endif

  assign row_inc = row_cnt_q + C_ROW_W'(1);

  // Next-state logic: FSM transitions and counter advance.
  // Counters only move on cycles where seq_vld=1.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    num_rows_d = num_rows_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    gray_d     = gray_q;
    seq_vld    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d = num_rows;
          row_cnt_d  = '0;
          addr_d     = '0;
          sel_d      = 1'b1;
          gray_d     = 2'b00;
          // A zero-row run skips RUN entirely.
          state_d    = (num_rows != '0) ? S_RUN : S_DRAIN;
        end
      end
      S_RUN: begin
        seq_vld = ~stall_eff;
        if (!stall_eff) begin
          if (addr_q == ADDR_LAST) begin
            addr_d = '0;
            sel_d  = ~sel_q;
            // The second half of a row pass ends here, so the row pass is complete.
            if (!sel_q) begin
              gray_d    = {gray_q[0], ~gray_q[1]};
              row_cnt_d = row_inc;
              if (row_inc == num_rows_q) begin
                state_d = S_DRAIN;
              end
            end
          end else begin
            addr_d = addr_q + 3'd1;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers. rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      num_rows_q <= '0;
      addr_q     <= '0;
      sel_q      <= 1'b1;
      gray_q     <= 2'b00;
      wvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      num_rows_q <= num_rows_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      gray_q     <= gray_d;
      wvld_q     <= seq_vld;
    end
  end

  assign gray_code         = gray_q;
  assign sequence_selector = sel_q;
  assign seq_data_addr     = addr_q;
  assign wht_addr_vld      = wvld_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DRAIN);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequence_ctrl.sv
// Testbench for cnn_layer_accel_weight_sequence_ctrl.
// Each run is modelled as a flat list of table requests {gray, selector, addr},
// derived arithmetically from the request index.
module tb_cnn_layer_accel_weight_sequence_ctrl;

  localparam int L = 5;
  localparam int W = 8;
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] num_rows = '0;
  logic         stall = 1'b0;
  logic [1:0]   gray_code;
  logic         sequence_selector;
  logic [2:0]   seq_data_addr;
  logic         seq_vld;
  logic         wht_addr_vld;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  cnn_layer_accel_weight_sequence_ctrl #(.C_SEQ_LEN(L), .C_ROW_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_rows(num_rows),
    .stall(stall),
    .gray_code(gray_code),
    .sequence_selector(sequence_selector),
    .seq_data_addr(seq_data_addr),
    .seq_vld(seq_vld),
    .wht_addr_vld(wht_addr_vld),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // scoreboard
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Request k of a run: row = k/(2L), half = first when (k mod 2L) < L,
  // addr = k mod L, gray = binary-to-gray of (row mod 4).
  task automatic load_model(input int n);
    int row, pos, g;
    logic [1:0] gc;
    logic [2:0] a;
    exp_q.delete();
    for (int k = 0; k < 2 * L * n; k++) begin
      row = k / (2 * L);
      pos = k % (2 * L);
      g   = row % 4;
      gc  = 2'(g ^ (g >> 1));
      a   = 3'(pos % L);
      exp_q.push_back({gc, (pos < L), a});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gray"}, 32'(gray_code), 32'd0);
    check({tag, "_sel"}, 32'(sequence_selector), 32'd1);
    check({tag, "_addr"}, 32'(seq_data_addr), 32'd0);
    check({tag, "_seq_vld"}, 32'(seq_vld), 32'd0);
    check({tag, "_wht_vld"}, 32'(wht_addr_vld), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // driver: one run of n rows.
  // stall_pct: chance of stall in each cycle.
  // repulse_at: cycle at which start is pulsed again; -1 means never.
  // abort_at: rst is raised right after this many requests; 0 means never.
  task automatic run(input int n, input int stall_pct, input int repulse_at, input int abort_at);
    int  cyc, nstall, budget, popped;
    bit  prev_vld, se, finished;
    logic [5:0] obs;
    load_model(n);
    cyc = 0; nstall = 0; popped = 0; prev_vld = 1'b0; finished = 1'b0;
    budget = 4 * L * n + 50;
    start = 1'b1;
    num_rows = W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    num_rows = W'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    while (!finished && cyc < budget) begin
      stall = ($urandom_range(99) < stall_pct);
      if (cyc == repulse_at) begin
        start = 1'b1;
        num_rows = W'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
      end
      #1;
      se = STALL_EN && stall;
      check("wht_addr_vld", 32'(wht_addr_vld), 32'(prev_vld));
      if (exp_q.size() > 0) begin
        obs = {gray_code, sequence_selector, seq_data_addr};
        check("seq_vld", 32'(seq_vld), 32'(!se));
        check("gray_sel_addr", 32'(obs), 32'(exp_q[0]));
        check("busy_run", 32'(busy), 32'd1);
        check("done_run", 32'(done), 32'd0);
        prev_vld = !se;
        if (se) nstall++;
        else begin
          void'(exp_q.pop_front());
          popped++;
        end
        if (abort_at > 0 && popped == abort_at && !se) begin
          rst = 1'b1; start = 1'b1; stall = 1'b1;
          @(posedge clk); #1;
          check_reset_outputs("abort");
          rst = 1'b0; start = 1'b0; stall = 1'b0;
          exp_q.delete();
          repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_idle_busy", 32'(busy), 32'd0);
          end
          return;
        end
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd1);
        check("seq_vld_at_done", 32'(seq_vld), 32'd0);
        check("done_latency", 32'(cyc), 32'(2 * L * n + nstall));
        finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) check("run_timeout", 32'd1, 32'd0);
    start = 1'b0;
    stall = 1'($urandom_range(1));
    @(posedge clk); #1;
    check("done_single_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("seq_vld_idle", 32'(seq_vld), 32'd0);
    check("wht_vld_idle", 32'(wht_addr_vld), 32'd0);
    stall = 1'b0;
  endtask

  initial begin
    // Reset while start and stall are also high: rst must win.
    rst = 1'b1; start = 1'b1; num_rows = W'(3); stall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(busy), 32'd0);

    run(1, 0, -1, 0);        // single row pass
    run(4, 0, -1, 0);        // full gray cycle
    run(0, 0, -1, 0);        // zero rows
    run(1, 30, -1, 0);       // random stall
    run(2, 0, -1, 6);        // abort on the 6th request
    run(1, 0, -1, 0);        // fresh run after abort
    run(3, 0, 12, 0);        // start re-pulsed during RUN
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(0, 6), $urandom_range(0, 40), $urandom_range(0, 30), 0);
    end
    run(255, 10, 100, 0);    // largest row count

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
